// File: rtl/regfile_wb.sv
// Y86-64 register file with writeback-stage decode: two combinational read
// ports, E/M write ports (M wins on collision) and a sticky halt flag.
module regfile_wb (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        wb_en,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] rsp_dbg,
  output logic        halted
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREGS  = 15;
  localparam logic [3:0]  R_NONE = 4'hF;
  localparam logic [3:0]  R_RSP  = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [DATA_W-1:0] regs [0:NREGS-1];

  logic [3:0] src_a;
  logic [3:0] src_b;
  logic [3:0] dst_e;
  logic [3:0] dst_m;
  logic       we_e;
  logic       we_m;
  logic       halt_now;

  // Register specifier decode from the instruction code
  always_comb begin
    src_a = R_NONE;
    src_b = R_NONE;
    dst_e = R_NONE;
    dst_m = R_NONE;
    unique case (icode)
      I_CMOV: begin
        src_a = rA;
        dst_e = cnd ? rB : R_NONE;
      end
      I_IRMOV: dst_e = rB;
      I_RMMOV: begin
        src_a = rA;
        src_b = rB;
      end
      I_MRMOV: begin
        src_b = rB;
        dst_m = rA;
      end
      I_OPQ: begin
        src_a = rA;
        src_b = rB;
        dst_e = rB;
      end
      I_CALL: begin
        src_b = R_RSP;
        dst_e = R_RSP;
      end
      I_RET: begin
        src_a = R_RSP;
        src_b = R_RSP;
        dst_e = R_RSP;
      end
      I_PUSHQ: begin
        src_a = rA;
        src_b = R_RSP;
        dst_e = R_RSP;
      end
      I_POPQ: begin
        src_a = R_RSP;
        src_b = R_RSP;
        dst_e = R_RSP;
        dst_m = rA;
      end
      default: ;
    endcase
  end

  // Write qualification; the M port shadows the E port on a shared destination
  always_comb begin
    halt_now = wb_en & ~halted & (icode == I_HALT);
    we_m     = wb_en & ~halted & (dst_m != R_NONE);
    we_e     = wb_en & ~halted & (dst_e != R_NONE) & (dst_e != dst_m);
  end

  // Reads see only pre-edge contents; no same-cycle bypass
  always_comb begin
    valA = '0;
    valB = '0;
    if (src_a != R_NONE) valA = regs[src_a];
    if (src_b != R_NONE) valB = regs[src_b];
  end

  assign rsp_dbg = regs[R_RSP];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
      halted <= 1'b0;
    end else begin
      if (halt_now) halted <= 1'b1;
      for (int i = 0; i < int'(NREGS); i++) begin
        if (we_m && dst_m == 4'(i))      regs[i] <= valM;
        else if (we_e && dst_e == 4'(i)) regs[i] <= valE;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed and randomized checks of regfile_wb against a behavioural model.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  icode, rA, rB;
  logic        cnd;
  logic [63:0] valE, valM;
  logic        wb_en;
  logic [63:0] valA, valB, rsp_dbg;
  logic        halted;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [63:0] mr [0:15];
  logic        mhalt;

  regfile_wb dut (
    .clk(clk), .reset(reset), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
    .valE(valE), .valM(valM), .wb_en(wb_en), .valA(valA), .valB(valB),
    .rsp_dbg(rsp_dbg), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_src_a(logic [3:0] ic, logic [3:0] a);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return a;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_src_b(logic [3:0] ic, logic [3:0] b);
    if (ic inside {4'h4, 4'h5, 4'h6}) return b;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_e(logic [3:0] ic, logic [3:0] b, logic c);
    if (ic inside {4'h3, 4'h6}) return b;
    if (ic == 4'h2) return c ? b : 4'hF;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_m(logic [3:0] ic, logic [3:0] a);
    if (ic inside {4'h5, 4'hB}) return a;
    return 4'hF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                     input logic c, input logic [63:0] e, input logic [63:0] m,
                     input logic w);
    icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m; wb_en = w;
  endtask

  // One rising edge, then advance the model with the inputs it saw
  task automatic step();
    logic [3:0] de, dm;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 16; i++) mr[i] = '0;
      mhalt = 1'b0;
    end else if (wb_en && !mhalt) begin
      if (icode == 4'h0) mhalt = 1'b1;
      else begin
        de = m_dst_e(icode, rB, cnd);
        dm = m_dst_m(icode, rA);
        if (de != 4'hF) mr[de] = valE;
        if (dm != 4'hF) mr[dm] = valM;
      end
    end
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set(4'h3, 4'hF, 4'h2, 1'b0, 64'hBAD0, 64'hBAD1, 1'b1);
    step();
    reset = 1'b0;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 15; i++) begin
      set(4'h6, 4'(i), 4'(14 - i), 1'b0, '0, '0, 1'b0);
      settle();
      chk({tag, "_a"}, valA, mr[i]);
      chk({tag, "_b"}, valB, mr[14 - i]);
    end
  endtask

  task automatic read_reg(input string tag, input logic [3:0] r, input logic [63:0] exp);
    set(4'h6, r, r, 1'b0, '0, '0, 1'b0);
    settle();
    chk(tag, valA, exp);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mr[i] = '0;
    mhalt = 1'b0;
    reset = 1'b0;
    set(4'hF, 4'hF, 4'hF, 1'b0, '0, '0, 1'b0);
    @(negedge clk);

    // Reset overrides a pending write; everything reads zero afterwards
    do_reset();
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_rsp", rsp_dbg, 64'd0);
    sweep("rst_sweep");

    // irmovq on first edge after reset, read back through opq
    set(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, '0, 1'b1);
    step();
    set(4'h6, 4'h2, 4'h2, 1'b0, '0, '0, 1'b0);
    settle();
    chk("irmov_valA", valA, 64'h1234);
    chk("irmov_valB", valB, 64'h1234);

    // cmov gated by cnd
    set(4'h3, 4'hF, 4'h1, 1'b0, 64'd5, '0, 1'b1);
    step();
    set(4'h2, 4'h0, 4'h1, 1'b0, 64'd9, '0, 1'b1);
    step();
    read_reg("cmov_cnd0", 4'h1, 64'd5);
    set(4'h2, 4'h0, 4'h1, 1'b1, 64'd9, '0, 1'b1);
    step();
    read_reg("cmov_cnd1", 4'h1, 64'd9);

    // popq %rsp: M port wins
    set(4'h3, 4'hF, 4'h4, 1'b0, 64'h100, '0, 1'b1);
    step();
    set(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hAAAA, 1'b1);
    step();
    chk("popq_rsp", rsp_dbg, 64'hAAAA);

    // pushq: valA read before edge, only rsp written
    set(4'h3, 4'hF, 4'h3, 1'b0, 64'd7, '0, 1'b1);
    step();
    set(4'h3, 4'hF, 4'h4, 1'b0, 64'h100, '0, 1'b1);
    step();
    set(4'hA, 4'h3, 4'hF, 1'b0, 64'hF8, '0, 1'b1);
    settle();
    chk("pushq_valA", valA, 64'd7);
    chk("pushq_valB", valB, 64'h100);
    step();
    chk("pushq_rsp", rsp_dbg, 64'hF8);
    read_reg("pushq_r3", 4'h3, 64'd7);

    // No forwarding of same-edge write data
    set(4'h6, 4'h2, 4'h2, 1'b0, 64'h55, '0, 1'b1);
    step();
    set(4'h6, 4'h2, 4'h2, 1'b0, 64'h66, '0, 1'b1);
    settle();
    chk("nofwd_old", valA, 64'h55);
    step();
    read_reg("nofwd_new", 4'h2, 64'h66);

    // Destination 0xF and wb_en=0 leave state alone
    set(4'h3, 4'hF, 4'hF, 1'b0, 64'hDEAD, '0, 1'b1);
    step();
    set(4'h3, 4'hF, 4'h6, 1'b0, 64'd77, '0, 1'b0);
    step();
    sweep("nowr_sweep");
    set(4'h6, 4'hF, 4'hF, 1'b0, '0, '0, 1'b0);
    settle();
    chk("none_valA", valA, 64'd0);
    chk("none_valB", valB, 64'd0);

    // Halt is sticky, blocks writes, cleared by reset
    set(4'h0, 4'hF, 4'hF, 1'b0, '0, '0, 1'b1);
    step();
    chk("halt_set", 64'(halted), 64'd1);
    set(4'h3, 4'hF, 4'h5, 1'b0, 64'd1, '0, 1'b1);
    step();
    chk("halt_hold", 64'(halted), 64'd1);
    read_reg("halt_r5", 4'h5, 64'd0);
    do_reset();
    chk("halt_clr", 64'(halted), 64'd0);
    sweep("halt_rst_sweep");

    // Randomized traffic against the model
    step();
    for (int n = 0; n < 400; n++) begin
      logic [3:0] ic, sa, sb;
      ic = 4'($urandom_range(0, 15));
      if (ic == 4'h0 && $urandom_range(0, 3) != 0) ic = 4'h6;
      set(ic, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
          1'($urandom_range(0, 3) != 0));
      reset = (mhalt && $urandom_range(0, 3) == 0) || ($urandom_range(0, 63) == 0);
      settle();
      sa = m_src_a(icode, rA);
      sb = m_src_b(icode, rB);
      chk("rnd_valA", valA, mr[sa]);
      chk("rnd_valB", valB, mr[sb]);
      step();
      reset = 1'b0;
      chk("rnd_rsp", rsp_dbg, mr[4]);
      chk("rnd_halted", 64'(halted), 64'(mhalt));
    end
    sweep("final_sweep");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
